// File: rtl/vector_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vexec_pkg
//  Brief    : Shared opcodes, sequencer state encoding and chunk-offset helper
//             for the vector execution unit.
//  Revision : 1.0 - initial release
// ============================================================================
package vexec_pkg;

    localparam logic [4:0] VADD  = 5'd0;
    localparam logic [4:0] VSUB  = 5'd1;
    localparam logic [4:0] VAND  = 5'd2;
    localparam logic [4:0] VOR   = 5'd3;
    localparam logic [4:0] VXOR  = 5'd4;
    localparam logic [4:0] VSLL  = 5'd5;
    localparam logic [4:0] VSRL  = 5'd6;
    localparam logic [4:0] VMOVS = 5'd7;
    localparam logic [4:0] VLD   = 5'd8;
    localparam logic [4:0] VST   = 5'd9;
    localparam logic [4:0] VMUL  = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_FIN  = 2'd3
    } vexec_state_e;

    // Bit offset of chunk 'pass' inside a packed vector register.
    function automatic int unsigned chunk_lsb(input int unsigned pass,
                                              input int unsigned lanes,
                                              input int unsigned elem_w);
        return pass * lanes * elem_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_exec_unit_lane.sv
`default_nettype none
// ============================================================================
//  Module   : vector_lane
//  Brief    : One ELEM_W-bit combinational vector ALU lane.
//             Macro VEXEC_SATURATE_EN: unsigned-saturating VADD/VSUB and a
//             saturating VMUL; otherwise VADD/VSUB wrap and VMUL yields 0.
//  Revision : 1.0 - initial release
// ============================================================================
module vector_lane
    import vexec_pkg::*;
#(
    parameter int ELEM_W = 8
) (
    input  logic [4:0]                  op_i,
    input  logic [ELEM_W-1:0]           a_i,
    input  logic [ELEM_W-1:0]           b_i,
    input  logic [$clog2(ELEM_W)-1:0]   shamt_i,
    input  logic [ELEM_W-1:0]           scalar_i,
    output logic [ELEM_W-1:0]           y_o
);

`ifdef VEXEC_SATURATE_EN
    logic [ELEM_W:0]     w_sum;
    logic [2*ELEM_W-1:0] w_prod;
    assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
    assign w_prod = {{ELEM_W{1'b0}}, a_i} * {{ELEM_W{1'b0}}, b_i};
`endif

    // Element-wise operation select; results are truncated to ELEM_W bits.
    always_comb begin
        y_o = '0;
        case (op_i)
`ifdef VEXEC_SATURATE_EN
            VADD:  y_o = w_sum[ELEM_W] ? '1 : w_sum[ELEM_W-1:0];
            VSUB:  y_o = (a_i < b_i) ? '0 : (a_i - b_i);
            VMUL:  y_o = (|w_prod[2*ELEM_W-1:ELEM_W]) ? '1 : w_prod[ELEM_W-1:0];
`else
            VADD:  y_o = a_i + b_i;
            VSUB:  y_o = a_i - b_i;
`endif
            VAND:  y_o = a_i & b_i;
            VOR:   y_o = a_i | b_i;
            VXOR:  y_o = a_i ^ b_i;
            VSLL:  y_o = a_i << shamt_i;
            VSRL:  y_o = a_i >> shamt_i;
            VMOVS: y_o = scalar_i;
            default: y_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vector_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : vector_exec_unit
//  Brief    : Vector register file, NUM_LANES-wide lane array and pass
//             sequencer processing NUM_ELEMS elements in PASSES chunks, with
//             a handshaked beat-addressed data-memory port for VLD/VST.
//             Macro VEXEC_SATURATE_EN: saturating VADD/VSUB, VMUL legal.
//  Revision : 1.0 - initial release
// ============================================================================
module vector_exec_unit
    import vexec_pkg::*;
#(
    parameter int ELEM_W    = 8,
    parameter int NUM_VREGS = 16,
    parameter int NUM_ELEMS = 8,
    parameter int NUM_LANES = 4,
    parameter int PASSES    = NUM_ELEMS / NUM_LANES,
    parameter int RIDX_W    = $clog2(NUM_VREGS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [4:0]                    id_op,
    input  logic [RIDX_W-1:0]             id_vs,
    input  logic [RIDX_W-1:0]             id_vt,
    input  logic [RIDX_W-1:0]             id_vd,
    input  logic [$clog2(ELEM_W)-1:0]     id_shamt,
    input  logic [15:0]                   id_imm16,
    input  logic [31:0]                   id_scalar,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [15:0]                   mem_addr,
    output logic [NUM_LANES*ELEM_W-1:0]   mem_wdata,
    input  logic [NUM_LANES*ELEM_W-1:0]   mem_rdata,
    input  logic                          mem_ack,
    output logic [NUM_LANES*ELEM_W-1:0]   lane_out,
    output logic                          done,
    output logic                          err
);

    localparam int CHUNK_W = NUM_LANES * ELEM_W;
    localparam int VEC_W   = NUM_ELEMS * ELEM_W;
    localparam int PASS_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int LSB_W   = (VEC_W > 1) ? $clog2(VEC_W) : 1;
    localparam int SH_W    = $clog2(ELEM_W);

    vexec_state_e          state_q, state_d;
    logic [PASS_W-1:0]     pass_q, pass_d;
    logic                  gap_q, gap_d;
    logic                  err_q, err_d;
    logic [4:0]            op_q;
    logic [RIDX_W-1:0]     vs_q, vt_q, vd_q;
    logic [SH_W-1:0]       shamt_q;
    logic [15:0]           imm_q;
    logic [ELEM_W-1:0]     scalar_q;
    logic [VEC_W-1:0]      rf_q [NUM_VREGS];
    logic [CHUNK_W-1:0]    lane_out_q;

    logic                  w_accept, w_last, w_legal_alu, w_rf_we;
    logic [LSB_W-1:0]      w_chunk_lsb;
    logic [CHUNK_W-1:0]    w_a_chunk, w_b_chunk, w_alu_chunk, w_rf_wdata;
    logic                  w_unused_scalar;

    assign w_unused_scalar = ^id_scalar[31:ELEM_W];
    assign w_accept    = issue_valid && (state_q == ST_IDLE);
    assign w_last      = (pass_q == PASS_W'(PASSES - 1));
    assign w_chunk_lsb = LSB_W'(chunk_lsb(32'(pass_q), NUM_LANES, ELEM_W));
    assign w_a_chunk   = rf_q[vs_q][w_chunk_lsb +: CHUNK_W];
    assign w_b_chunk   = rf_q[vt_q][w_chunk_lsb +: CHUNK_W];
    assign lane_out    = lane_out_q;

`ifdef VEXEC_SATURATE_EN
    assign w_legal_alu = (id_op <= VMOVS) || (id_op == VMUL);
`else
    assign w_legal_alu = (id_op <= VMOVS);
`endif

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        vector_lane #(.ELEM_W(ELEM_W)) u_lane (
            .op_i     (op_q),
            .a_i      (w_a_chunk[l*ELEM_W +: ELEM_W]),
            .b_i      (w_b_chunk[l*ELEM_W +: ELEM_W]),
            .shamt_i  (shamt_q),
            .scalar_i (scalar_q),
            .y_o      (w_alu_chunk[l*ELEM_W +: ELEM_W])
        );
    end

    // Sequencer next-state, register-file write enable and port outputs.
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        gap_d       = gap_q;
        err_d       = err_q;
        w_rf_we     = 1'b0;
        w_rf_wdata  = w_alu_chunk;
        issue_ready = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    pass_d = '0;
                    gap_d  = 1'b0;
                    err_d  = 1'b0;
                    if (w_legal_alu) begin
                        state_d = ST_EXEC;
                    end else if ((id_op == VLD) || (id_op == VST)) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_FIN;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                w_rf_we = 1'b1;
                if (w_last) state_d = ST_FIN;
                else        pass_d  = pass_q + 1'b1;
            end
            ST_MEM: begin
                if (gap_q) begin
                    // One idle cycle between beats; a stray ack here is ignored.
                    gap_d = 1'b0;
                end else begin
                    mem_req  = 1'b1;
                    mem_we   = (op_q == VST);
                    mem_addr = imm_q + 16'(pass_q);
                    if (op_q == VST) mem_wdata = w_a_chunk;
                    if (mem_ack) begin
                        w_rf_we    = (op_q == VLD);
                        w_rf_wdata = mem_rdata;
                        if (w_last) begin
                            state_d = ST_FIN;
                        end else begin
                            pass_d = pass_q + 1'b1;
                            gap_d  = 1'b1;
                        end
                    end
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer control registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pass_q  <= '0;
            gap_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

    // Instruction fields captured at accept and held for the whole instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            vs_q     <= '0;
            vt_q     <= '0;
            vd_q     <= '0;
            shamt_q  <= '0;
            imm_q    <= '0;
            scalar_q <= '0;
        end else if (w_accept) begin
            op_q     <= id_op;
            vs_q     <= id_vs;
            vt_q     <= id_vt;
            vd_q     <= id_vd;
            shamt_q  <= id_shamt;
            imm_q    <= id_imm16;
            scalar_q <= id_scalar[ELEM_W-1:0];
        end
    end

    // Register file: one chunk of vd written per ALU pass or load beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VREGS; i++) rf_q[i] <= '0;
        end else if (w_rf_we) begin
            rf_q[vd_q][w_chunk_lsb +: CHUNK_W] <= w_rf_wdata;
        end
    end

    // Last ALU result chunk, visible on lane_out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                    lane_out_q <= '0;
        else if (state_q == ST_EXEC)  lane_out_q <= w_alu_chunk;
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_exec_unit
//  Brief    : Self-checking bench for vector_exec_unit with a whole-vector
//             reference model of the register file.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vector_exec_unit;
    import vexec_pkg::*;

    localparam int ELEM_W = 8, NVR = 16, NE = 8, NL = 4, PASSES = NE / NL;
    localparam int CW = NL * ELEM_W;
    localparam int EMOD = 1 << ELEM_W;

    logic clock = 1'b0, reset = 1'b1, issue_valid = 1'b0, issue_ready;
    logic [4:0] id_op = '0;
    logic [3:0] id_vs = '0, id_vt = '0, id_vd = '0;
    logic [2:0] id_shamt = '0;
    logic [15:0] id_imm16 = '0;
    logic [31:0] id_scalar = '0;
    logic mem_req, mem_we, mem_ack = 1'b0, done, err;
    logic [15:0] mem_addr;
    logic [CW-1:0] mem_wdata, mem_rdata = '0, lane_out;

    int total = 0, bad = 0;
    int mrf [NVR][NE];

    vector_exec_unit dut (
        .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .id_op(id_op), .id_vs(id_vs), .id_vt(id_vt), .id_vd(id_vd), .id_shamt(id_shamt),
        .id_imm16(id_imm16), .id_scalar(id_scalar), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .lane_out(lane_out), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int ref_elem(input logic [4:0] op, input int a, input int b,
                                    input int sh, input int sc);
        int s;
        case (op)
`ifdef VEXEC_SATURATE_EN
            VADD: begin s = a + b; return (s > EMOD - 1) ? EMOD - 1 : s; end
            VSUB: begin s = a - b; return (s < 0) ? 0 : s; end
            VMUL: begin s = a * b; return (s > EMOD - 1) ? EMOD - 1 : s; end
`else
            VADD: return (a + b) % EMOD;
            VSUB: return (a - b + EMOD) % EMOD;
`endif
            VAND: return a & b;
            VOR:  return a | b;
            VXOR: return a ^ b;
            VSLL: return (a << sh) % EMOD;
            VSRL: return a >> sh;
            VMOVS: return sc % EMOD;
            default: return 0;
        endcase
    endfunction

    function automatic logic [CW-1:0] model_chunk(input int r, input int p);
        logic [CW-1:0] c;
        for (int l = 0; l < NL; l++) c[l*ELEM_W +: ELEM_W] = 8'(mrf[r][p*NL + l]);
        return c;
    endfunction

    task automatic do_issue(input logic [4:0] op, input int vs, input int vt, input int vd,
                            input int sh, input int imm, input int sc);
        check("issue_ready_idle", issue_ready, 1);
        issue_valid = 1'b1; id_op = op; id_vs = 4'(vs); id_vt = 4'(vt); id_vd = 4'(vd);
        id_shamt = 3'(sh); id_imm16 = 16'(imm); id_scalar = sc;
        step();
        issue_valid = 1'b0; id_op = 5'(VAND); id_scalar = $urandom;
    endtask

    task automatic run_alu(input logic [4:0] op, input int vs, input int vt, input int vd,
                           input int sh, input int sc);
        int res [NE];
        int n;
        logic [CW-1:0] last;
        for (int e = 0; e < NE; e++) res[e] = ref_elem(op, mrf[vs][e], mrf[vt][e], sh, sc);
        for (int l = 0; l < NL; l++) last[l*ELEM_W +: ELEM_W] = 8'(res[(PASSES-1)*NL + l]);
        do_issue(op, vs, vt, vd, sh, 0, sc);
        n = 1;
        while (done !== 1'b1 && n < 10) begin step(); n++; end
        check("alu_latency", n, PASSES + 1);
        check("alu_err", err, 0);
        check("alu_lane_out", lane_out, last);
        for (int e = 0; e < NE; e++) mrf[vd][e] = res[e];
        step();
        check("alu_ready_after", issue_ready, 1);
    endtask

    task automatic run_illegal(input logic [4:0] op);
        do_issue(op, 1, 2, 3, 0, 0, 0);
        check("ill_done", done, 1);
        check("ill_err", err, 1);
        step();
        check("ill_done_drop", done, 0);
        check("ill_ready", issue_ready, 1);
    endtask

    task automatic run_mem(input bit is_st, input int r, input int imm, input int dly,
                           input logic [CW-1:0] beats [PASSES]);
        int n;
        logic [15:0] ea;
        do_issue(is_st ? VST : VLD, r, 0, r, 0, imm, 0);
        for (int p = 0; p < PASSES; p++) begin
            n = 0;
            while (mem_req !== 1'b1 && n < 10) begin step(); n++; end
            ea = 16'(imm + p);
            check("mem_req", mem_req, 1);
            check("mem_we", mem_we, is_st);
            check("mem_addr", mem_addr, ea);
            check("mem_busy_ready", issue_ready, 0);
            if (is_st) check("mem_wdata", mem_wdata, model_chunk(r, p));
            repeat (dly) step();
            check("mem_hold_req", mem_req, 1);
            check("mem_hold_addr", mem_addr, ea);
            if (is_st) check("mem_hold_wdata", mem_wdata, model_chunk(r, p));
            mem_rdata = beats[p];
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (!is_st)
                for (int l = 0; l < NL; l++) mrf[r][p*NL + l] = int'(beats[p][l*ELEM_W +: ELEM_W]);
            if (p < PASSES - 1) begin
                check("mem_gap", mem_req, 0);
                mem_ack = 1'b1;
                step();
                mem_ack = 1'b0;
            end
        end
        check("mem_done", done, 1);
        check("mem_err", err, 0);
        step();
    endtask

    task automatic verify_reg(input int r, input int dly);
        logic [CW-1:0] none [PASSES];
        for (int p = 0; p < PASSES; p++) none[p] = '0;
        run_mem(1'b1, r, int'($urandom_range(0, 16'hFFFF)), dly, none);
    endtask

    initial begin
        logic [CW-1:0] beats [PASSES];
        logic [4:0] rop;
        for (int r = 0; r < NVR; r++) for (int e = 0; e < NE; e++) mrf[r][e] = 0;

        #2;
        check("rst_ready", issue_ready, 1);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_lane_out", lane_out, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        step();
        reset = 1'b0;
        step();

        run_alu(VMOVS, 0, 0, 1, 0, 32'hABCD_0005);
        run_alu(VMOVS, 0, 0, 2, 0, 32'h0000_0003);
        run_alu(VADD, 1, 2, 3, 0, 0);
        check("vadd_lane_out_direct", lane_out, 32'h0808_0808);

        run_alu(VMOVS, 0, 0, 1, 0, 32'hF0);
        run_alu(VMOVS, 0, 0, 2, 0, 32'h20);
        run_alu(VADD, 1, 2, 5, 0, 0);

        for (int p = 0; p < PASSES; p++) beats[p] = '0;
        run_mem(1'b1, 3, 16'hFFFF, 3, beats);

        beats[0] = 32'h0403_0201;
        beats[1] = 32'h0807_0605;
        run_mem(1'b0, 4, 16'h0040, 1, beats);
        verify_reg(4, 0);

        run_illegal(5'h1F);
`ifdef VEXEC_SATURATE_EN
        run_alu(VMUL, 1, 2, 6, 0, 0);
`else
        run_illegal(VMUL);
`endif
        verify_reg(3, 1);

        for (int i = 0; i < 24; i++) begin
            rop = 5'($urandom_range(0, 7));
            run_alu(rop, int'($urandom_range(0, NVR-1)), int'($urandom_range(0, NVR-1)),
                    int'($urandom_range(0, NVR-1)), int'($urandom_range(0, ELEM_W-1)), int'($urandom));
        end
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < PASSES; p++) beats[p] = $urandom;
            run_mem(1'b0, int'($urandom_range(0, NVR-1)), int'($urandom_range(0, 16'hFFFF)),
                    int'($urandom_range(0, 2)), beats);
        end
        for (int r = 0; r < NVR; r++) verify_reg(r, int'($urandom_range(0, 2)));

        // Reset in the middle of a load, during its second pass.
        do_issue(VLD, 0, 0, 7, 0, 16'h0100, 0);
        mem_rdata = 32'hDEAD_BEEF;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        check("pre_rst_addr", mem_addr, 16'h0101);
        #2 reset = 1'b1;
        #1;
        check("arst_ready", issue_ready, 1);
        check("arst_req", mem_req, 0);
        check("arst_we", mem_we, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_wdata", mem_wdata, 0);
        check("arst_lane_out", lane_out, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        step();
        reset = 1'b0;
        for (int r = 0; r < NVR; r++) for (int e = 0; e < NE; e++) mrf[r][e] = 0;
        step();
        run_alu(VADD, 1, 2, 3, 0, 0);
        check("post_rst_lane_out", lane_out, 0);
        verify_reg(7, 0);
        verify_reg(4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_exec_unit.md
Name: vector_exec_unit

Overview:
- Parametrised vector execution unit: owns the vector register file, a NUM_LANES-wide lane array and a pass sequencer that processes NUM_ELEMS elements in NUM_ELEMS/NUM_LANES passes.
- Accepts decoded vector instructions over a valid/ready handshake.
- Drives a handshaked data-memory port for VLD/VST.
- Sits between the decode stage and data memory; replaces the fixed single-pass, 4-lane vector top.

Parameters:
- ELEM_W, 8, bits per vector element.
- NUM_VREGS, 16, number of vector registers (power of 2).
- NUM_ELEMS, 8, elements per vector register.
- NUM_LANES, 4, parallel lanes; NUM_ELEMS must be an integer multiple of NUM_LANES.
- PASSES, NUM_ELEMS/NUM_LANES, derived; passes per instruction.
- RIDX_W, $clog2(NUM_VREGS), derived; register index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  unit can accept an instruction (high only in IDLE).
- id_op  in  5  opcode (values in vexec_pkg).
- id_vs  in  RIDX_W  source register A.
- id_vt  in  RIDX_W  source register B.
- id_vd  in  RIDX_W  destination register.
- id_shamt  in  $clog2(ELEM_W)  shift amount.
- id_imm16  in  16  memory base address (beat address).
- id_scalar  in  32  scalar operand for VMOVS; low ELEM_W bits are used.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  16  beat address.
- mem_wdata  out  NUM_LANES*ELEM_W  store data.
- mem_rdata  in  NUM_LANES*ELEM_W  load data, valid with mem_ack.
- mem_ack  in  1  completes the current request.
- lane_out  out  NUM_LANES*ELEM_W  last lane result chunk (registered).
- done  out  1  one-cycle pulse on instruction completion.
- err  out  1  one-cycle pulse together with done when the opcode is illegal.

Behaviour:
- Reset (asynchronous): FSM goes to IDLE; pass counter = 0; every register-file element = 0. Outputs: issue_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, lane_out=0, done=0, err=0.
- Accept: on issue_valid && issue_ready, latch all id_* fields, set pass p=0, go to the state for the opcode.
- States: IDLE, EXEC, MEM, FIN.
- Transitions:
  - IDLE→EXEC for ALU ops and VMOVS.
  - IDLE→MEM for VLD and VST.
  - IDLE→FIN (err=1) for illegal opcodes.
- EXEC: each cycle, lanes compute chunk p, i.e. elements p*NUM_LANES .. p*NUM_LANES+NUM_LANES-1.
  - Chunk p of vd is written and lane_out updated in the same cycle; then p increments.
  - After p==PASSES-1 → FIN.
  - ALU latency: PASSES+1 cycles from accept to done.
  - Each pass reads only chunk p before writing it, so vd==vs or vd==vt is legal.
- ALU ops, element-wise, result truncated mod 2^ELEM_W:
  - VADD, VSUB, VAND, VOR, VXOR.
  - VSLL / VSRL (logical shift by shamt).
  - VMOVS: broadcast id_scalar[ELEM_W-1:0] to all elements.
- MEM state:
  - Drives mem_req=1, mem_addr=imm16+p (16-bit wrap-around, 0xFFFF+1=0x0000).
  - VST: mem_we=1, mem_wdata=chunk p of vs. VLD: mem_we=0.
  - mem_req and all request fields hold stable until mem_ack.
  - On mem_ack: VLD writes mem_rdata into chunk p of vd; p increments. mem_req drops for one cycle between beats.
  - mem_ack while mem_req=0 is ignored. After the last ack → FIN.
- FIN: done=1 for one cycle, err as set, then → IDLE. issue_ready is asserted again in the cycle after done.
- Reset mid-operation aborts the instruction immediately. Partially written chunks are lost because the whole file clears.

Optional Feature:
- Macro VEXEC_SATURATE_EN.
- Defined: VADD/VSUB saturate as unsigned (clamp to 2^ELEM_W-1 and 0), and opcode VMUL (low ELEM_W bits of product, saturated) becomes legal.
- Undefined: VADD/VSUB wrap modulo 2^ELEM_W, and VMUL is illegal (err pulse, no write).

Decomposition:
- Package vexec_pkg holds:
  - the opcode localparams: VADD=0, VSUB=1, VAND=2, VOR=3, VXOR=4, VSLL=5, VSRL=6, VMOVS=7, VLD=8, VST=9, VMUL=10;
  - the FSM state enum;
  - the helper function for the chunk index.
- Sub-module vector_lane: one ELEM_W-bit ALU, purely combinational, instantiated NUM_LANES times via generate.
- Register file, sequencer and memory port stay in vector_exec_unit.

Test Plan:
- Default params. Fill v1 via VMOVS 0x05 and v2 via VMOVS 0x03, then VADD v3=v1+v2 → two EXEC cycles; done on cycle 3 after accept; v3 all 0x08; lane_out=0x08080808.
- VMOVS 0xF0 into v1 and 0x20 into v2, then VADD → every element 0x10 without the macro, 0xFF with VEXEC_SATURATE_EN.
- VST v3 imm16=0xFFFF with mem_ack delayed 3 cycles per beat:
  - addresses 0xFFFF then 0x0000;
  - req/addr/wdata held stable during each wait;
  - done after the second ack.
- VLD v4 from rdata beats 0x04030201 and 0x08070605 → v4 elements 01..08 in order; issue_ready=0 throughout the load.
- Illegal opcode 0x1F → done=1 and err=1 in the cycle after accept; no register changes.
- Assert reset during pass 1 of a VLD → all outputs at reset values asynchronously; issue_ready=1; subsequent VADD of zero registers gives 0.
